// File: rtl/dco_nco_if.sv
// Control/status bundle of the digitally controlled oscillator (dco_nco).
//
// Ports (as seen from the DCO, modport slave):
//   enable_i     in   level request to run the oscillator
//   cc_update_i  in   single-cycle strobe, dco_cc_i valid this cycle
//   dco_cc_i     in   signed control code from the loop filter
//   dco_clk_o    out  oscillator output (accumulator MSB)
//   wrap_o       out  one-cycle pulse after an accumulator carry-out
//   phase_o      out  current accumulator value
//   fcw_o        out  frequency control word in use
//   sat_o        out  high while fcw_o is clamped
//   running_o    out  high while the oscillator is running or stopping
// The master modport is the loop-filter / controller side.
interface dco_nco_if #(
    parameter int DCO_CC_WIDTH = 9,
    parameter int ACC_WIDTH    = 16
);
    logic                           enable_i;
    logic                           cc_update_i;
    logic signed [DCO_CC_WIDTH-1:0] dco_cc_i;
    logic                           dco_clk_o;
    logic                           wrap_o;
    logic        [ACC_WIDTH-1:0]    phase_o;
    logic        [ACC_WIDTH-1:0]    fcw_o;
    logic                           sat_o;
    logic                           running_o;

    modport master (
        output enable_i, cc_update_i, dco_cc_i,
        input  dco_clk_o, wrap_o, phase_o, fcw_o, sat_o, running_o
    );

    modport slave (
        input  enable_i, cc_update_i, dco_cc_i,
        output dco_clk_o, wrap_o, phase_o, fcw_o, sat_o, running_o
    );
endinterface

// File: rtl/dco_nco.sv
// Numerically controlled model of a DCO: a phase accumulator stepped by a
// frequency control word derived from a signed control code.
//
// Ports:
//   gen_clk_i  in   system clock, all state changes on its rising edge
//   reset_i    in   asynchronous, active-high reset
//   bus        dco_nco_if.slave (enable, control-code strobe, outputs)
//
// fcw = clamp(CENTER_FCW + cc * 2^GAIN_SHIFT, 1 .. 2^(ACC_WIDTH-1)).
// A stop request lets the accumulator run until its next carry so the last
// dco_clk_o high phase is never cut short.
module dco_nco #(
    parameter int DCO_CC_WIDTH = 9,
    parameter int ACC_WIDTH    = 16,
    parameter int CENTER_FCW   = 2048,
    parameter int GAIN_SHIFT   = 2
) (
    input  logic      gen_clk_i,
    input  logic      reset_i,
    dco_nco_if.slave  bus
);

    // Wide enough that centre + shifted code can never overflow.
    localparam int RAW_W = ((ACC_WIDTH > DCO_CC_WIDTH + GAIN_SHIFT) ?
                            ACC_WIDTH : (DCO_CC_WIDTH + GAIN_SHIFT)) + 2;

    localparam logic signed [RAW_W-1:0] CENTER_RAW = RAW_W'(CENTER_FCW);
    localparam logic        [RAW_W-1:0] MAX_RAW    = RAW_W'(1) << (ACC_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t                         state;
    logic        [ACC_WIDTH-1:0]    acc;
    logic signed [DCO_CC_WIDTH-1:0] cc_r;
    logic        [ACC_WIDTH-1:0]    fcw_r;
    logic                           sat_r;
    logic                           wrap_r;
    logic                           running_r;

    logic signed [RAW_W-1:0]        cc_ext;
    logic signed [RAW_W-1:0]        raw;
    logic        [ACC_WIDTH:0]      clamped;
    logic        [ACC_WIDTH:0]      sum;
    logic                           carry;

    // Returns {sat, fcw}; used both for the live word and the reset value.
    function automatic logic [ACC_WIDTH:0] clamp_fcw(input logic signed [RAW_W-1:0] r);
        if (r < $signed(RAW_W'(1)))
            return {1'b1, ACC_WIDTH'(1)};
        else if (r > $signed(MAX_RAW))
            return {1'b1, MAX_RAW[ACC_WIDTH-1:0]};
        else
            return {1'b0, r[ACC_WIDTH-1:0]};
    endfunction

    always_comb begin
        cc_ext  = {{(RAW_W - DCO_CC_WIDTH){cc_r[DCO_CC_WIDTH-1]}}, cc_r};
        raw     = CENTER_RAW + (cc_ext <<< GAIN_SHIFT);
        clamped = clamp_fcw(raw);
        // One extra bit catches the carry, including the exact 2^ACC_WIDTH case.
        sum     = {1'b0, acc} + {1'b0, fcw_r};
        carry   = sum[ACC_WIDTH];
    end

    // NOTE: every register here uses non-blocking assignments so all of them
    // see the pre-edge values of each other; blocking would chain updates.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state            <= IDLE;
            acc              <= '0;
            cc_r             <= '0;
            {sat_r, fcw_r}   <= clamp_fcw(CENTER_RAW);
            wrap_r           <= 1'b0;
            running_r        <= 1'b0;
        end else begin
            // The control path is not gated by state: a strobe is always taken.
            if (bus.cc_update_i)
                cc_r <= bus.dco_cc_i;
            {sat_r, fcw_r} <= clamped;

            unique case (state)
                IDLE: begin
                    acc    <= '0;
                    wrap_r <= 1'b0;
                    if (bus.enable_i) begin
                        state     <= RUN;
                        running_r <= 1'b1;
                    end
                end

                RUN: begin
                    acc    <= sum[ACC_WIDTH-1:0];
                    wrap_r <= carry;
                    if (!bus.enable_i)
                        state <= STOPPING;
                end

                STOPPING: begin
                    wrap_r <= carry;
                    if (bus.enable_i) begin
                        // Resume without touching the phase.
                        state <= RUN;
                        acc   <= sum[ACC_WIDTH-1:0];
                    end else if (carry) begin
                        state     <= IDLE;
                        acc       <= '0;
                        running_r <= 1'b0;
                    end else begin
                        acc <= sum[ACC_WIDTH-1:0];
                    end
                end

                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    wrap_r    <= 1'b0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from flops.
    assign bus.dco_clk_o = acc[ACC_WIDTH-1];
    assign bus.phase_o   = acc;
    assign bus.fcw_o     = fcw_r;
    assign bus.sat_o     = sat_r;
    assign bus.wrap_o    = wrap_r;
    assign bus.running_o = running_r;

endmodule

// File: tb/tb_dco_nco.sv
// Self-checking bench for dco_nco: a default instance checked every cycle
// against an arithmetic reference model, plus a GAIN_SHIFT=8 instance for
// the clamp boundaries.
module tb_dco_nco;

    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    dco_nco_if #(.DCO_CC_WIDTH(9), .ACC_WIDTH(16)) bus1 ();
    dco_nco_if #(.DCO_CC_WIDTH(9), .ACC_WIDTH(16)) bus2 ();

    dco_nco dut1 (
        .gen_clk_i (clk),
        .reset_i   (reset_i),
        .bus       (bus1)
    );

    dco_nco #(.GAIN_SHIFT(8)) dut2 (
        .gen_clk_i (clk),
        .reset_i   (reset_i),
        .bus       (bus2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of dut1: phase as a plain integer in [0, 65536).
    int m_phase, m_cc, m_fcw;
    bit m_sat, m_wrap, m_on, m_last_en;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void exp_fcw(input int cc, input int shift, output int fcw, output bit sat);
        int r;
        r = 2048 + cc * (1 << shift);
        if (r < 1) begin
            fcw = 1; sat = 1'b1;
        end else if (r > 32768) begin
            fcw = 32768; sat = 1'b1;
        end else begin
            fcw = r; sat = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_cc      = 0;
        exp_fcw(0, 2, m_fcw, m_sat);
        m_wrap    = 1'b0;
        m_on      = 1'b0;
        m_last_en = 1'b0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_step();
        int nxt;
        bit en, carry;
        if (reset_i) begin
            model_reset();
        end else begin
            en = bus1.enable_i;
            if (!m_on) begin
                m_wrap  = 1'b0;
                m_phase = 0;
                if (en) m_on = 1'b1;
            end else begin
                nxt    = m_phase + m_fcw;
                carry  = (nxt >= 65536);
                m_wrap = carry;
                // Already stopping, still not enabled, and carried: park at zero.
                if (!m_last_en && !en && carry) begin
                    m_phase = 0;
                    m_on    = 1'b0;
                end else begin
                    m_phase = nxt % 65536;
                end
            end
            m_last_en = en;
            exp_fcw(m_cc, 2, m_fcw, m_sat);
            if (bus1.cc_update_i) m_cc = int'(bus1.dco_cc_i);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_phase"},   bus1.phase_o,   m_phase);
        check({tag, "_dco_clk"}, bus1.dco_clk_o, (m_phase >> 15) & 1);
        check({tag, "_wrap"},    bus1.wrap_o,    m_wrap);
        check({tag, "_fcw"},     bus1.fcw_o,     m_fcw);
        check({tag, "_sat"},     bus1.sat_o,     m_sat);
        check({tag, "_running"}, bus1.running_o, m_on);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    // Ticks until dut1 shows wrap_o; n = ticks taken, or -1 if none within limit.
    task automatic wait_wrap(input string tag, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick(tag);
            if (bus1.wrap_o === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_to_phase(input string tag, input int target, input int limit);
        bit found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick(tag);
            if (bus1.phase_o === 16'(target)) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_reached"}, found, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, wraps, v;
        int e_fcw;
        bit e_sat;

        // Reset state of both instances.
        reset_i          = 1'b1;
        bus1.enable_i    = 1'b0;
        bus1.cc_update_i = 1'b0;
        bus1.dco_cc_i    = '0;
        bus2.enable_i    = 1'b0;
        bus2.cc_update_i = 1'b0;
        bus2.dco_cc_i    = '0;
        model_reset();
        #12;
        compare_all("reset");
        check("reset_fcw_const", bus1.fcw_o, 2048);
        check("reset2_fcw", bus2.fcw_o, 2048);
        check("reset2_sat", bus2.sat_o, 0);
        reset_i = 1'b0;

        // Idle hold without enable.
        repeat (3) tick("idle_hold");

        // Free running at the centre frequency.
        bus1.enable_i = 1'b1;
        wait_wrap("run_c", 100, n);
        wait_wrap("run_c", 100, n);
        check("period_2048", n, 32);

        // Control code +64: fcw changes exactly two edges after the strobe.
        bus1.dco_cc_i    = 9'sd64;
        bus1.cc_update_i = 1'b1;
        tick("strobe_p64");
        bus1.cc_update_i = 1'b0;
        check("p64_lat1_fcw", bus1.fcw_o, 2048);
        tick("p64_lat2");
        check("p64_lat2_fcw", bus1.fcw_o, 2304);
        check("p64_sat", bus1.sat_o, 0);
        repeat (40) tick("run_p64");

        // Control code -256: half the centre frequency.
        bus1.dco_cc_i    = -9'sd256;
        bus1.cc_update_i = 1'b1;
        tick("strobe_m256");
        bus1.cc_update_i = 1'b0;
        tick("m256_lat2");
        check("m256_fcw", bus1.fcw_o, 1024);
        wait_wrap("run_m", 200, n);
        wait_wrap("run_m", 200, n);
        check("period_1024", n, 64);
        check("m256_sat", bus1.sat_o, 0);

        // Randomised strobes, codes and enable toggling against the model.
        for (int i = 0; i < 500; i++) begin
            v                = int'($urandom_range(511)) - 256;
            bus1.dco_cc_i    = v[8:0];
            bus1.cc_update_i = ($urandom_range(7) == 0);
            if ($urandom_range(29) == 0) bus1.enable_i = ~bus1.enable_i;
            tick("rand");
        end
        bus1.cc_update_i = 1'b0;

        // Back to centre frequency, then stop and restart from zero phase.
        bus1.dco_cc_i    = '0;
        bus1.cc_update_i = 1'b1;
        tick("strobe_zero");
        bus1.cc_update_i = 1'b0;
        bus1.enable_i    = 1'b0;
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            tick("drain");
            if (bus1.running_o === 1'b0) begin
                n = i;
                break;
            end
        end
        check("drain_done", n > 0, 1);
        check("drain_fcw", bus1.fcw_o, 2048);

        // Stop request at phase 0x4000: drains for 24 edges with one wrap.
        bus1.enable_i = 1'b1;
        run_to_phase("to_4000", 16'h4000, 100);
        bus1.enable_i = 1'b0;
        n = -1;
        wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            tick("stopping");
            if (bus1.wrap_o === 1'b1) wraps++;
            if (bus1.running_o === 1'b0) begin
                n = i;
                break;
            end
        end
        check("stop_cycles", n, 24);
        check("stop_wraps", wraps, 1);
        check("stop_phase", bus1.phase_o, 0);
        check("stop_dco_clk", bus1.dco_clk_o, 0);
        repeat (3) tick("idle_after_stop");

        // Re-enable while stopping: phase continues without a jump.
        bus1.enable_i = 1'b1;
        tick("restart");
        run_to_phase("to_4000b", 16'h4000, 100);
        bus1.enable_i = 1'b0;
        repeat (5) tick("stop_short");
        bus1.enable_i = 1'b1;
        tick("resume");
        check("resume_phase", bus1.phase_o, 16'h7000);
        check("resume_running", bus1.running_o, 1);

        // Asynchronous reset in the middle of a cycle at phase 0x9000.
        run_to_phase("to_9000", 16'h9000, 100);
        #2;
        reset_i = 1'b1;
        #1;
        check("areset_dco_clk", bus1.dco_clk_o, 0);
        check("areset_wrap", bus1.wrap_o, 0);
        check("areset_phase", bus1.phase_o, 0);
        check("areset_running", bus1.running_o, 0);
        model_reset();
        tick("in_reset");
        reset_i = 1'b0;
        // enable_i is still high: one edge to start, then 32 edges to the wrap.
        tick("start_after_reset");
        check("start_running", bus1.running_o, 1);
        wait_wrap("after_reset", 100, n);
        check("first_wrap_after_reset", n, 32);

        // GAIN_SHIFT=8 instance: upper clamp.
        bus2.dco_cc_i    = 9'sd255;
        bus2.cc_update_i = 1'b1;
        tick("g8_strobe_hi");
        bus2.cc_update_i = 1'b0;
        tick("g8_lat_hi");
        exp_fcw(255, 8, e_fcw, e_sat);
        check("g8_hi_fcw", bus2.fcw_o, e_fcw);
        check("g8_hi_fcw_const", bus2.fcw_o, 32768);
        check("g8_hi_sat", bus2.sat_o, e_sat);
        bus2.enable_i = 1'b1;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            tick("g8_wait");
            if (bus2.wrap_o === 1'b1) begin
                n = i;
                break;
            end
        end
        check("g8_first_wrap", n > 0, 1);
        tick("g8_p1");
        check("g8_period_a_wrap", bus2.wrap_o, 0);
        check("g8_period_a_clk", bus2.dco_clk_o, 1);
        tick("g8_p2");
        check("g8_period_b_wrap", bus2.wrap_o, 1);
        check("g8_period_b_clk", bus2.dco_clk_o, 0);

        // GAIN_SHIFT=8 instance: lower clamp.
        bus2.dco_cc_i    = 9'h100;
        bus2.cc_update_i = 1'b1;
        tick("g8_strobe_lo");
        bus2.cc_update_i = 1'b0;
        tick("g8_lat_lo");
        exp_fcw(-256, 8, e_fcw, e_sat);
        check("g8_lo_fcw", bus2.fcw_o, e_fcw);
        check("g8_lo_fcw_const", bus2.fcw_o, 1);
        check("g8_lo_sat", bus2.sat_o, e_sat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dco_nco.md
DCO_NCO -- requirements
Module: dco_nco

Interface
REQ-001 Parameter DCO_CC_WIDTH, default 9: width of the signed control code input.
REQ-002 Parameter ACC_WIDTH, default 16: phase accumulator width.
REQ-003 Parameter CENTER_FCW, default 2048: free-running frequency control word.
REQ-004 Parameter GAIN_SHIFT, default 2: left shift applied to the control code (DCO gain).
REQ-005 gen_clk_i  input  1: system clock; all state updates on its rising edge.
REQ-006 reset_i  input  1: reset, asynchronous, active-high.
REQ-007 enable_i  input  1: level request to run the oscillator.
REQ-008 cc_update_i  input  1: single-cycle strobe; dco_cc_i is valid this cycle.
REQ-009 dco_cc_i  input  DCO_CC_WIDTH signed: control code from the loop filter.
REQ-010 dco_clk_o  output  1: registered oscillator output (accumulator MSB).
REQ-011 wrap_o  output  1: one-cycle pulse on accumulator wrap.
REQ-012 phase_o  output  ACC_WIDTH: current accumulator value.
REQ-013 fcw_o  output  ACC_WIDTH: frequency control word in use.
REQ-014 sat_o  output  1: high while fcw_o is clamped.
REQ-015 running_o  output  1: high in RUN or STOPPING.

Function
REQ-016 Control code latch: cc_r SHALL load dco_cc_i on any cycle where cc_update_i=1, independent of state; otherwise hold.
REQ-017 FCW computation SHALL use full-precision signed arithmetic (at least max(ACC_WIDTH, DCO_CC_WIDTH+GAIN_SHIFT)+2 bits): raw = CENTER_FCW + (cc_r * 2^GAIN_SHIFT); no intermediate overflow.
REQ-018 Clamp: raw < 1 -> 1; raw > 2^(ACC_WIDTH-1) -> 2^(ACC_WIDTH-1); sat_o=1 in both cases, else 0.
REQ-019 fcw_o and sat_o SHALL be registered from cc_r; latency: strobe at cycle N -> cc_r at N+1 -> fcw_o/sat_o at N+2 -> first accumulator step with new fcw at N+3 edge.
REQ-020 State machine states: IDLE, RUN, STOPPING.
REQ-021 IDLE: accumulator held at 0, dco_clk_o=0, wrap_o=0; enable_i=1 -> RUN.
REQ-022 RUN: acc <= (acc + fcw_o) mod 2^ACC_WIDTH each cycle; enable_i=0 -> STOPPING (the accumulate step still occurs on that edge).
REQ-023 STOPPING: keep accumulating; on the cycle the add carries out of ACC_WIDTH, load acc=0 and go to IDLE (no runt pulse on dco_clk_o); enable_i=1 returns to RUN without clearing acc.
REQ-024 wrap_o SHALL be 1 for exactly the cycle following an add that carried out, in RUN or STOPPING; never in IDLE.
REQ-025 dco_clk_o SHALL equal the registered MSB of acc; phase_o equals acc.
REQ-026 Exact wrap (acc+fcw = 2^ACC_WIDTH) counts as a carry: acc becomes 0, wrap_o asserts.
REQ-027 A strobe during a state transition SHALL be accepted; the fcw change is not gated by state.

Reset
REQ-028 While reset_i=1: state=IDLE, acc=0, cc_r=0, fcw_o=CENTER_FCW clamped, sat_o per clamp of CENTER_FCW, dco_clk_o=0, wrap_o=0, running_o=0.
REQ-029 Reset asserted mid-cycle of oscillation SHALL force all of the above immediately; after release, the block stays IDLE until enable_i=1 is sampled.

Verification
REQ-030 Defaults, cc=0, enable_i=1 -> fcw_o=2048, wrap_o every 32 cycles, dco_clk_o 16 high/16 low.
REQ-031 Strobe cc=+64 -> fcw_o=2304 exactly 2 cycles after strobe; cc=-256 -> fcw_o=1024, period 64 cycles; sat_o=0 throughout.
REQ-032 GAIN_SHIFT=8: cc=+255 -> fcw_o=32768, sat_o=1, period 2; cc=-256 -> fcw_o=1, sat_o=1.
REQ-033 Deassert enable_i with acc=0x4000, fcw=2048 -> STOPPING for 24 cycles, one wrap_o pulse, then IDLE with acc=0, dco_clk_o=0; re-assert inside STOPPING -> RUN with no phase discontinuity.
REQ-034 Assert reset_i mid-run with acc=0x9000 -> dco_clk_o, wrap_o, phase_o, running_o = 0 immediately, without waiting for a clock edge; after release and enable_i=1 the first wrap occurs 32 cycles later.
